// File: rtl/fifo_pkg.sv
// fifo_pkg: shared sizing and pointer helpers for the FIFO family.
//   level_width(depth): bits needed to hold a count of 0..depth.
//   ptr_next(p, depth): advance a storage pointer, wrapping to 0 after depth-1.
package fifo_pkg;

    function automatic int level_width(int depth);
        return $clog2(depth + 1);
    endfunction

    // Explicit wrap compare so non-power-of-two depths wrap correctly.
    function automatic int unsigned ptr_next(int unsigned p, int unsigned depth);
        return (p + 1 == depth) ? 0 : p + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x WIDTH storage, one synchronous write port, one asynchronous read port, no reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write address (0..DEPTH-1)
//   wdata : write word
//   raddr : read address (0..DEPTH-1)
//   rdata : word at raddr, combinational
module fifo_mem #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 10,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_level.sv
// fifo_level: first-word fall-through FIFO with level, almost-full/empty and sticky error flags.
//   clk, res_n            : clock, asynchronous active-low reset
//   wdata, shift_in       : write word and write request
//   shift_out             : read request (pops the head)
//   clr_err               : synchronous clear of overflow/underflow
//   rdata                 : head word, zero when empty
//   full, empty           : level == DEPTH / level == 0
//   almost_full/_empty    : level >= AF_LEVEL / level <= AE_LEVEL
//   level                 : current entry count
//   overflow, underflow   : sticky error flags
module fifo_level
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 10,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                          clk,
    input  logic                          res_n,
    input  logic [WIDTH-1:0]              wdata,
    input  logic                          shift_in,
    input  logic                          shift_out,
    input  logic                          clr_err,
    output logic [WIDTH-1:0]              rdata,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [level_width(DEPTH)-1:0] level,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int LW = level_width(DEPTH);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             ovf_q, ovf_d, udf_q, udf_d;
    logic             wr, rd;
    logic [WIDTH-1:0] mem_rdata;

    // All status is decoded from registered level only.
    assign full         = level_q == LW'(DEPTH);
    assign empty        = level_q == '0;
    assign almost_full  = level_q >= LW'(AF_LEVEL);
    assign almost_empty = level_q <= LW'(AE_LEVEL);
    assign level        = level_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;
    assign rdata        = empty ? '0 : mem_rdata;

    // A write into a full FIFO is allowed only when the head is popped in the same cycle.
    assign wr = shift_in & (~full | shift_out);
    assign rd = shift_out & ~empty;

    always_comb begin
        wptr_d  = wr ? PW'(ptr_next(32'(wptr_q), DEPTH)) : wptr_q;
        rptr_d  = rd ? PW'(ptr_next(32'(rptr_q), DEPTH)) : rptr_q;
        level_d = (wr & ~rd) ? level_q + LW'(1) :
                  (rd & ~wr) ? level_q - LW'(1) : level_q;
        // A fresh error outranks clr_err in the same cycle.
        ovf_d   = (shift_in & full & ~shift_out) | (ovf_q & ~clr_err);
        udf_d   = (shift_out & empty & ~shift_in) | (udf_q & ~clr_err);
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    fifo_mem #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .AW   (PW)
    ) u_mem (
        .clk  (clk),
        .we   (wr),
        .waddr(wptr_q),
        .wdata(wdata),
        .raddr(rptr_q),
        .rdata(mem_rdata)
    );

endmodule

// File: tb/tb_fifo_level.sv
// tb_fifo_level: directed table-driven bench for fifo_level (WIDTH=16, DEPTH=10, AF=8, AE=2).
module tb_fifo_level;

    logic        clk = 1'b0;
    logic        res_n = 1'b0;
    logic        shift_in = 1'b0, shift_out = 1'b0, clr_err = 1'b0;
    logic [15:0] wdata = '0;
    logic [15:0] rdata;
    logic        full, empty, almost_full, almost_empty, overflow, underflow;
    logic [3:0]  level;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        si, so, ce;
        logic [15:0] wd;
        int          lvl;
        logic [15:0] rd;
        logic        ovf, udf;
    } vec_t;

    vec_t        vecs[$];
    logic [15:0] words[10];
    logic [15:0] model[$];

    always #5 clk = ~clk;

    fifo_level #(
        .WIDTH(16), .DEPTH(10), .AF_LEVEL(8), .AE_LEVEL(2)
    ) dut (
        .clk(clk), .res_n(res_n), .wdata(wdata), .shift_in(shift_in),
        .shift_out(shift_out), .clr_err(clr_err), .rdata(rdata), .full(full),
        .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .level(level), .overflow(overflow), .underflow(underflow)
    );

    function automatic void add(logic si, logic so, logic ce, logic [15:0] wd,
                                int lvl, logic [15:0] rd, logic ovf, logic udf);
        vec_t v;
        v.si = si; v.so = so; v.ce = ce; v.wd = wd;
        v.lvl = lvl; v.rd = rd; v.ovf = ovf; v.udf = udf;
        vecs.push_back(v);
    endfunction

    // Flags order: full, empty, almost_full, almost_empty, overflow, underflow.
    task automatic check(string name, int lvl, logic [15:0] rd, logic ovf, logic udf);
        logic [25:0] act, exp;
        act = {level, rdata, full, empty, almost_full, almost_empty, overflow, underflow};
        exp = {4'(lvl), rd, lvl == 10, lvl == 0, lvl >= 8, lvl <= 2, ovf, udf};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got level=%0d rdata=%h flags=%b, expected level=%0d rdata=%h flags=%b",
                     name, level, rdata, act[5:0], lvl, rd, exp[5:0]);
        end
    endtask

    task automatic step(logic si, logic so, logic ce, logic [15:0] wd);
        shift_in = si; shift_out = so; clr_err = ce; wdata = wd;
        @(posedge clk);
        #1;
        shift_in = 1'b0; shift_out = 1'b0; clr_err = 1'b0; wdata = '0;
    endtask

    task automatic reset_spike(string name);
        res_n = 1'b0;
        #2;
        check(name, 0, 16'h0000, 1'b0, 1'b0);
        #1;
        res_n = 1'b1;
        model.delete();
    endtask

    initial begin
        words = '{16'hAFFE, 16'hCAFE, 16'hBEEF, 16'hF00D, 16'h1234,
                  16'h5678, 16'h9ABC, 16'hDEF0, 16'h0BAD, 16'hFA11};
        for (int i = 0; i < 10; i++) add(1, 0, 0, words[i], i + 1, words[0], 0, 0);
        for (int i = 0; i < 5; i++)  add(1, 0, 0, 16'hDEAD, 10, words[0], 1, 0);
        for (int k = 1; k <= 10; k++) add(0, 1, 0, 0, 10 - k, (k < 10) ? words[k] : 16'h0000, 1, 0);
        for (int i = 0; i < 3; i++)  add(0, 1, 0, 0, 0, 0, 1, 1);
        add(0, 0, 1, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 0, 1);
        add(0, 0, 1, 0, 0, 0, 0, 0);
        add(1, 1, 0, 16'h1234, 1, 16'h1234, 0, 0);
        for (int i = 1; i <= 9; i++) add(1, 0, 0, 16'h0100 + 16'(i), 1 + i, 16'h1234, 0, 0);
        add(1, 1, 0, 16'h5555, 10, 16'h0101, 0, 0);
        for (int k = 1; k <= 10; k++)
            add(0, 1, 0, 0, 10 - k, (k <= 8) ? 16'h0101 + 16'(k) : (k == 9) ? 16'h5555 : 16'h0000, 0, 0);

        #12;
        check("reset", 0, 16'h0000, 1'b0, 1'b0);
        res_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            step(vecs[i].si, vecs[i].so, vecs[i].ce, vecs[i].wd);
            check($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].rd, vecs[i].ovf, vecs[i].udf);
        end

        // Wrap: hold level at 3 with simultaneous push/pop across several pointer wraps.
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 16'hB000 + 16'(i));
            model.push_back(16'hB000 + 16'(i));
            check("wrap_fill", i + 1, model[0], 1'b0, 1'b0);
        end
        for (int i = 0; i < 25; i++) begin
            step(1, 1, 0, 16'hA000 + 16'(i));
            model.push_back(16'hA000 + 16'(i));
            void'(model.pop_front());
            check($sformatf("wrap%0d", i), 3, model[0], 1'b0, 1'b0);
        end

        // Async reset at level 5, mid-cycle, 3-unit pulse.
        for (int i = 0; i < 2; i++) begin
            step(1, 0, 0, 16'hC000 + 16'(i));
            model.push_back(16'hC000 + 16'(i));
        end
        check("lvl5", 5, model[0], 1'b0, 1'b0);
        reset_spike("rst_lvl5");
        step(0, 0, 0, 0);
        check("post_rst_lvl5", 0, 16'h0000, 1'b0, 1'b0);

        // Async reset while full with overflow set.
        for (int i = 0; i < 11; i++) step(1, 0, 0, 16'hD000 + 16'(i));
        check("full_ovf", 10, 16'hD000, 1'b1, 1'b0);
        reset_spike("rst_full");
        step(0, 0, 0, 0);
        check("post_rst_full", 0, 16'h0000, 1'b0, 1'b0);
        step(1, 0, 0, 16'h7777);
        check("write_after_rst", 1, 16'h7777, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
